mul_float_result_fifo: RTL and testbench
========================================

MUL_FLOAT_RESULT_FIFO -- requirements
Module: mul_float_result_fifo

Interface
REQ-001 Parameter DEPTH, default 4: number of result entries; power of two, at least 2.
REQ-002 iCLOCK  input  1  clock; all state updates on the rising edge.
REQ-003 iRESET_SYNC  input  1  reset; synchronous and active-high.
REQ-004 iDATA_VALID  input  1  producer (float multiplier output stage) presents a result.
REQ-005 oDATA_BUSY  output  1  receiver cannot accept; producer shall hold iDATA while set.
REQ-006 iDATA  input  32  IEEE-754 single-precision result.
REQ-007 iFLUSH  input  1  synchronous clear of all buffered entries.
REQ-008 oRD_VALID  output  1  head entry available.
REQ-009 iRD_ACK  input  1  consumer pops the head entry.
REQ-010 oRD_DATA  output  32  head entry result word.
REQ-011 oRD_FLAGS  output  3  head entry class {nan, inf, zero}.
REQ-012 oCOUNT  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 oNAN_COUNT  output  16  saturating count of accepted NaN results.

Function
REQ-014 Push shall occur when iDATA_VALID=1 and oDATA_BUSY=0 in the same cycle; iDATA is written at the tail.
REQ-015 oDATA_BUSY shall equal (oCOUNT==DEPTH), decoded from registered state only; no combinational path from iRD_ACK or iDATA_VALID.
REQ-016 When full, a simultaneous pop shall not admit a push in that cycle; busy drops the following cycle.
REQ-017 Pop shall occur when iRD_ACK=1 and oRD_VALID=1; iRD_ACK while empty shall be ignored.
REQ-018 oRD_VALID shall equal (oCOUNT!=0); oRD_DATA/oRD_FLAGS shall reflect the head entry, registered storage read.
REQ-019 Pushed entry shall become visible at the output the cycle after the push: 1-cycle latency, no bypass.
REQ-020 Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
REQ-021 Read and write pointers shall wrap from DEPTH-1 to 0.
REQ-022 Flags shall be computed at push from iDATA:
  - nan = exp==8'hFF && fract!=0
  - inf = exp==8'hFF && fract==0
  - zero = exp==0 && fract==0 (sign ignored)
  - denormals shall give flags 3'b000.
REQ-023 oNAN_COUNT shall increment on each push with nan=1 and saturate at 16'hFFFF.
REQ-024 iFLUSH=1 shall clear pointers and count next edge and take precedence over a same-cycle push and pop, which are discarded. oNAN_COUNT is not cleared.
REQ-025 oRD_DATA/oRD_FLAGS content while oRD_VALID=0 is don't-care; verification shall not check it.

Reset
REQ-026 With iRESET_SYNC=1 at an edge, the following shall be cleared, and reset shall override iFLUSH, push and pop:
  - pointers = 0
  - oCOUNT = 0
  - oRD_VALID = 0
  - oDATA_BUSY = 0
  - oNAN_COUNT = 0
REQ-027 Storage array contents need no reset.
REQ-028 Reset asserted mid-stream shall drop all buffered entries; the first push after release shall be the head.

Verification
REQ-029 Push 3F800000, 7FC00000, 7F800000, 80000000 (DEPTH=4, no ack) -> after 4th push:
  - oCOUNT=4, oDATA_BUSY=1
  - pops in order return flags 000, 100, 010, 001
  - oNAN_COUNT=1
REQ-030 Full FIFO, iDATA_VALID=1 and iRD_ACK=1 same cycle -> that cycle pop only, oCOUNT=3; next cycle busy=0 and push accepted.
REQ-031 Count=2, push 40000000 with simultaneous pop -> oCOUNT stays 2; 40000000 emerges after both older entries.
REQ-032 Push/pop 9 entries continuously through DEPTH=4 -> data order preserved across pointer wrap; iRD_ACK on empty leaves oCOUNT=0.
REQ-033 Count=3 with iFLUSH=1, iDATA_VALID=1 and iRD_ACK=1 same cycle -> next cycle oCOUNT=0, oRD_VALID=0; oNAN_COUNT unchanged.
REQ-034 Preload oNAN_COUNT to FFFF by NaN pushes, push 7FC00001 -> oNAN_COUNT stays FFFF; assert iRESET_SYNC -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/mul_float_result_fifo.sv
// Result FIFO behind the float multiplier: buffers IEEE-754 words, classifies them
// on entry as {nan, inf, zero} and keeps a saturating count of NaN results accepted.
module mul_float_result_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       iCLOCK,
    input  logic                       iRESET_SYNC,
    input  logic                       iDATA_VALID,
    output logic                       oDATA_BUSY,
    input  logic [31:0]                iDATA,
    input  logic                       iFLUSH,
    output logic                       oRD_VALID,
    input  logic                       iRD_ACK,
    output logic [31:0]                oRD_DATA,
    output logic [2:0]                 oRD_FLAGS,
    output logic [$clog2(DEPTH):0]     oCOUNT,
    output logic [15:0]                oNAN_COUNT
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = 32;
    localparam int unsigned FW = 3;
    localparam int unsigned NW = 16;

    logic [DW-1:0] data_mem [DEPTH];
    logic [FW-1:0] flag_mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          busy;
    logic          valid;
    logic [NW-1:0] nan_count;

    logic          push;
    logic          pop;
    logic [CW-1:0] count_next;
    logic [7:0]    in_exp;
    logic [22:0]   in_fract;
    logic          in_nan;
    logic          in_inf;
    logic          in_zero;

    // Handshake qualification; busy and valid are flops, so no input-to-output path.
    always_comb begin
        push = iDATA_VALID & ~busy;
        pop  = iRD_ACK & valid;
    end

    // Classification of the incoming word; denormals fall through to all-zero flags.
    always_comb begin
        in_exp   = iDATA[30:23];
        in_fract = iDATA[22:0];
        in_nan   = (in_exp == 8'hFF) && (in_fract != 23'd0);
        in_inf   = (in_exp == 8'hFF) && (in_fract == 23'd0);
        in_zero  = (in_exp == 8'h00) && (in_fract == 23'd0);
    end

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    // Pointer/occupancy state; status flags are precomputed from the next count.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            busy   <= 1'b0;
            valid  <= 1'b0;
        end else if (iFLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            busy   <= 1'b0;
            valid  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            busy  <= (count_next == CW'(DEPTH));
            valid <= (count_next != CW'(0));
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (push && !iFLUSH && !iRESET_SYNC) begin
            data_mem[wr_ptr] <= iDATA;
            flag_mem[wr_ptr] <= {in_nan, in_inf, in_zero};
        end
    end

    // NaN statistics survive a flush but not a reset.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            nan_count <= '0;
        end else if (push && !iFLUSH && in_nan && (nan_count != {NW{1'b1}})) begin
            nan_count <= nan_count + NW'(1);
        end
    end

    always_comb begin
        oDATA_BUSY = busy;
        oRD_VALID  = valid;
        oCOUNT     = count;
        oNAN_COUNT = nan_count;
        oRD_DATA   = data_mem[rd_ptr];
        oRD_FLAGS  = flag_mem[rd_ptr];
    end

endmodule

// File: tb/tb_mul_float_result_fifo.sv
// Directed bench for mul_float_result_fifo (DEPTH=4): ordering, flags, handshake
// corner cases, flush, NaN saturation and reset.
module tb_mul_float_result_fifo;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        data_valid;
    logic        data_busy;
    logic [31:0] data;
    logic        flush;
    logic        rd_valid;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic [2:0]  rd_flags;
    logic [2:0]  count;
    logic [15:0] nan_count;

    int tests;
    int fails;
    int exp_nan;

    mul_float_result_fifo #(.DEPTH(DEPTH)) dut (
        .iCLOCK      (clk),
        .iRESET_SYNC (rst),
        .iDATA_VALID (data_valid),
        .oDATA_BUSY  (data_busy),
        .iDATA       (data),
        .iFLUSH      (flush),
        .oRD_VALID   (rd_valid),
        .iRD_ACK     (rd_ack),
        .oRD_DATA    (rd_data),
        .oRD_FLAGS   (rd_flags),
        .oCOUNT      (count),
        .oNAN_COUNT  (nan_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        data_valid = 1'b0;
        rd_ack     = 1'b0;
        flush      = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic push_one(input logic [31:0] d);
        data_valid = 1'b1;
        data       = d;
        step();
        data_valid = 1'b0;
    endtask

    task automatic pop_expect(input string name, input logic [31:0] d, input logic [2:0] f);
        tests++;
        if (rd_valid !== 1'b1 || rd_data !== d || rd_flags !== f) begin
            fails++;
            $display("FAIL %s: got valid=%b data=%h flags=%b, expected valid=1 data=%h flags=%b",
                     name, rd_valid, rd_data, rd_flags, d, f);
        end
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
    endtask

    task automatic check_count(input string name, input logic [2:0] c, input logic b, input logic v);
        tests++;
        if (count !== c || data_busy !== b || rd_valid !== v) begin
            fails++;
            $display("FAIL %s: got count=%0d busy=%b valid=%b, expected count=%0d busy=%b valid=%b",
                     name, count, data_busy, rd_valid, c, b, v);
        end
    endtask

    task automatic check_nan(input string name, input logic [15:0] n);
        tests++;
        if (nan_count !== n) begin
            fails++;
            $display("FAIL %s: got nan_count=%h expected %h", name, nan_count, n);
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_count("reset_status", 3'd0, 1'b0, 1'b0);
        check_nan("reset_nan", 16'h0000);
        exp_nan = 0;
    endtask

    task automatic test_flags();
        push_one(32'h3F800000);
        pop_expect_peek("latency_first", 32'h3F800000, 3'b000);
        push_one(32'h7FC00000);
        push_one(32'h7F800000);
        push_one(32'h80000000);
        exp_nan = 1;
        check_count("flags_full", 3'd4, 1'b1, 1'b1);
        check_nan("flags_nan", 16'h0001);
        pop_expect("flags_pop0", 32'h3F800000, 3'b000);
        pop_expect("flags_pop1", 32'h7FC00000, 3'b100);
        pop_expect("flags_pop2", 32'h7F800000, 3'b010);
        pop_expect("flags_pop3", 32'h80000000, 3'b001);
        check_count("flags_empty", 3'd0, 1'b0, 1'b0);
    endtask

    // Head check without popping.
    task automatic pop_expect_peek(input string name, input logic [31:0] d, input logic [2:0] f);
        tests++;
        if (rd_valid !== 1'b1 || rd_data !== d || rd_flags !== f) begin
            fails++;
            $display("FAIL %s: got valid=%b data=%h flags=%b, expected valid=1 data=%h flags=%b",
                     name, rd_valid, rd_data, rd_flags, d, f);
        end
    endtask

    task automatic test_class_edges();
        push_one(32'h00000001);
        push_one(32'hFF800000);
        push_one(32'h00800000);
        push_one(32'hFFFFFFFF);
        exp_nan = exp_nan + 1;
        pop_expect("denormal", 32'h00000001, 3'b000);
        pop_expect("neg_inf", 32'hFF800000, 3'b010);
        pop_expect("min_normal", 32'h00800000, 3'b000);
        pop_expect("neg_nan", 32'hFFFFFFFF, 3'b100);
        check_nan("class_nan", 16'(exp_nan));
    endtask

    task automatic test_full_pop_push();
        for (int i = 0; i < 4; i++) push_one(32'hA0000000 + 32'(i));
        check_count("full_before", 3'd4, 1'b1, 1'b1);
        data_valid = 1'b1;
        data       = 32'h12345678;
        rd_ack     = 1'b1;
        step();
        rd_ack = 1'b0;
        check_count("full_pop_only", 3'd3, 1'b0, 1'b1);
        step();
        data_valid = 1'b0;
        check_count("full_push_next", 3'd4, 1'b1, 1'b1);
        pop_expect("full_drain1", 32'hA0000001, 3'b000);
        pop_expect("full_drain2", 32'hA0000002, 3'b000);
        pop_expect("full_drain3", 32'hA0000003, 3'b000);
        pop_expect("full_drain4", 32'h12345678, 3'b000);
    endtask

    task automatic test_back_to_back();
        push_one(32'hB0000000);
        push_one(32'hB0000001);
        check_count("simul_before", 3'd2, 1'b0, 1'b1);
        data_valid = 1'b1;
        data       = 32'h40000000;
        rd_ack     = 1'b1;
        step();
        idle();
        check_count("simul_after", 3'd2, 1'b0, 1'b1);
        pop_expect("simul_old", 32'hB0000001, 3'b000);
        pop_expect("simul_new", 32'h40000000, 3'b000);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            data_valid = (i < 9);
            data       = 32'hC0000000 + 32'(i);
            rd_ack     = (i > 0);
            if (i > 0) pop_expect_peek("wrap_head", 32'hC0000000 + 32'(i - 1), 3'b000);
            step();
        end
        idle();
        check_count("wrap_empty", 3'd0, 1'b0, 1'b0);
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
        check_count("ack_on_empty", 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        push_one(32'hD0000000);
        push_one(32'hD0000001);
        push_one(32'hD0000002);
        check_count("flush_before", 3'd3, 1'b0, 1'b1);
        flush      = 1'b1;
        data_valid = 1'b1;
        data       = 32'h7FC00000;
        rd_ack     = 1'b1;
        step();
        idle();
        check_count("flush_after", 3'd0, 1'b0, 1'b0);
        check_nan("flush_nan", 16'(exp_nan));
        push_one(32'hD1000000);
        pop_expect("flush_next_head", 32'hD1000000, 3'b000);
    endtask

    task automatic test_nan_saturate();
        int n;
        n = 65535 - exp_nan;
        push_one(32'h7FC00000);
        data_valid = 1'b1;
        rd_ack     = 1'b1;
        data       = 32'h7FC00000;
        for (int i = 1; i < n; i++) step();
        idle();
        check_nan("nan_reach_max", 16'hFFFF);
        push_one(32'h7FC00001);
        check_nan("nan_saturated", 16'hFFFF);
        pop_expect("nan_head", 32'h7FC00000, 3'b100);
        pop_expect("nan_tail", 32'h7FC00001, 3'b100);
    endtask

    task automatic test_reset_mid();
        push_one(32'hE0000000);
        push_one(32'hE0000001);
        rst        = 1'b1;
        flush      = 1'b1;
        data_valid = 1'b1;
        data       = 32'h7FC00000;
        rd_ack     = 1'b1;
        step();
        idle();
        check_count("mid_reset_status", 3'd0, 1'b0, 1'b0);
        check_nan("mid_reset_nan", 16'h0000);
        push_one(32'hE1000000);
        pop_expect("mid_reset_head", 32'hE1000000, 3'b000);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        data  = '0;
        idle();
        test_reset();
        test_flags();
        test_class_edges();
        test_full_pop_push();
        test_back_to_back();
        test_wrap();
        test_flush();
        test_nan_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
